// File: rtl/audio_i2s_bridge_if.sv
// Parallel sample-side bus between the I2S bridge and the ANC core.
//
// Handshake: there is no valid/ready pair on this bus. audio_tx_load is a
// one-clk strobe marking the cycle in which the bridge captured tx_left and
// tx_right; audio_rx_down is a one-clk strobe marking the cycle in which
// rx_left and rx_right were both updated. The bridge never stalls and the
// consumer cannot back-pressure it. Each side must finish with a sample
// within one frame. Strobes are never queued.
interface audio_i2s_bridge_if #(
  parameter int DW = 16
);
  logic signed [DW-1:0] tx_left;
  logic signed [DW-1:0] tx_right;
  logic                 audio_tx_load;
  logic signed [DW-1:0] rx_left;
  logic signed [DW-1:0] rx_right;
  logic                 audio_rx_down;

  // Bridge side.
  modport slave (
    input  tx_left, tx_right,
    output audio_tx_load, rx_left, rx_right, audio_rx_down
  );

  // ANC core side.
  modport master (
    output tx_left, tx_right,
    input  audio_tx_load, rx_left, rx_right, audio_rx_down
  );
endinterface

// File: rtl/audio_i2s_bridge.sv
// I2S master bridge: divides clk down to BCLK/LRCK, serialises the DAC
// shadow words MSB first with a one-BCLK delay, and deserialises the ADC
// stream into rx_left/rx_right with a single strobe per frame.
module audio_i2s_bridge #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32,
  parameter int DW        = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic i2s_bclk,
  output logic i2s_lrck,
  input  logic i2s_adcdat,
  output logic i2s_dacdat,
  audio_i2s_bridge_if.slave bus
);
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = $clog2(DW);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DW_POS   = BIT_W'(DW);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_lrck;
  logic             r_dacdat;
  logic [DW-1:0]    r_tx_l, r_tx_r;
  logic             r_tx_load;
  logic             r_sync1, r_sync2;
  logic             r_cap_d1, r_cap_d2;
  logic             r_right_d1, r_right_d2;
  logic             r_last_d1, r_last_d2;
  logic [DW-1:0]    r_sh_l, r_sh_r;
  logic [DW-1:0]    r_rx_l, r_rx_r;
  logic             r_rx_down;

  logic             w_tick, w_rise, w_fall;
  logic [BIT_W-1:0] w_bit_nxt, w_nxt_slot, w_cur_slot;
  logic             w_nxt_right, w_cur_right;
  logic [DW-1:0]    w_dac_word;
  logic [IDX_W-1:0] w_dac_idx;
  logic             w_dac_bit, w_cap, w_cap_last;

  // Position of a frame bit inside its channel slot.
  function automatic logic [BIT_W-1:0] slot_of(input logic [BIT_W-1:0] b);
    return (b >= SLOT_N) ? (b - SLOT_N) : b;
  endfunction

  // Slot positions 1..DW carry sample bits; everything else is padding.
  function automatic logic in_data(input logic [BIT_W-1:0] s);
    return (s != '0) && (s <= DW_POS);
  endfunction

  // BCLK edge events and the frame position the next fall moves to.
  always_comb begin
    w_tick      = (r_div_cnt == DIV_LAST);
    w_rise      = w_tick && !r_bclk;
    w_fall      = w_tick && r_bclk;
    w_bit_nxt   = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    w_nxt_slot  = slot_of(w_bit_nxt);
    w_nxt_right = (w_bit_nxt >= SLOT_N);
    w_cur_slot  = slot_of(r_bit_cnt);
    w_cur_right = (r_bit_cnt >= SLOT_N);
    w_dac_word  = w_nxt_right ? r_tx_r : r_tx_l;
    w_dac_idx   = IDX_W'(DW_POS - w_nxt_slot);
    w_dac_bit   = in_data(w_nxt_slot) ? w_dac_word[w_dac_idx] : 1'b0;
    w_cap       = w_rise && in_data(w_cur_slot);
    w_cap_last  = w_cap && w_cur_right && (w_cur_slot == DW_POS);
  end

  // Clock divider: toggle BCLK every BCLK_HALF clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Frame bit counter and word select, both advanced on BCLK fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= BIT_LAST;
      r_lrck    <= 1'b0;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_nxt;
      r_lrck    <= w_nxt_right;
    end
  end

  // Latch the DAC words at frame start and flag the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_l    <= '0;
      r_tx_r    <= '0;
      r_tx_load <= 1'b0;
    end else begin
      r_tx_load <= w_fall && (w_bit_nxt == '0);
      if (w_fall && (w_bit_nxt == '0)) begin
        r_tx_l <= bus.tx_left;
        r_tx_r <= bus.tx_right;
      end
    end
  end

  // Serial DAC output, changed only on BCLK fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dacdat <= 1'b0;
    else if (w_fall) r_dacdat <= w_dac_bit;
  end

  // Two-flop synchroniser for the asynchronous ADC line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i2s_adcdat;
      r_sync2 <= r_sync1;
    end
  end

  // Delay each rise-edge capture by the synchroniser latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_d1   <= 1'b0;
      r_cap_d2   <= 1'b0;
      r_right_d1 <= 1'b0;
      r_right_d2 <= 1'b0;
      r_last_d1  <= 1'b0;
      r_last_d2  <= 1'b0;
    end else begin
      r_cap_d1   <= w_cap;
      r_cap_d2   <= r_cap_d1;
      r_right_d1 <= w_cur_right;
      r_right_d2 <= r_right_d1;
      r_last_d1  <= w_cap_last;
      r_last_d2  <= r_last_d1;
    end
  end

  // Shift the synchronised ADC bit into the current channel, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if (r_cap_d2) begin
      if (r_right_d2) r_sh_r <= {r_sh_r[DW-2:0], r_sync2};
      else            r_sh_l <= {r_sh_l[DW-2:0], r_sync2};
    end
  end

  // Publish both words together once the right LSB is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_l    <= '0;
      r_rx_r    <= '0;
      r_rx_down <= 1'b0;
    end else begin
      r_rx_down <= r_cap_d2 && r_last_d2;
      if (r_cap_d2 && r_last_d2) begin
        r_rx_l <= r_sh_l;
        r_rx_r <= {r_sh_r[DW-2:0], r_sync2};
      end
    end
  end

  assign i2s_bclk          = r_bclk;
  assign i2s_lrck          = r_lrck;
  assign i2s_dacdat        = r_dacdat;
  assign bus.audio_tx_load = r_tx_load;
  assign bus.rx_left       = r_rx_l;
  assign bus.rx_right      = r_rx_r;
  assign bus.audio_rx_down = r_rx_down;
endmodule

// File: tb/tb_audio_i2s_bridge.sv
// Bench for audio_i2s_bridge: default instance driven by a codec or
// loopback source frame by frame, plus a small BCLK_HALF=4/SLOT_BITS=18
// instance running in loopback.
module tb_audio_i2s_bridge;
  localparam int H  = 8;
  localparam int S  = 32;
  localparam int H2 = 4;
  localparam int S2 = 18;
  localparam int NV = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst2_n;

  logic bclk, lrck, adcdat, dacdat;
  logic bclk2, lrck2, adcdat2, dacdat2;
  audio_i2s_bridge_if #(.DW(16)) bus  ();
  audio_i2s_bridge_if #(.DW(16)) bus2 ();

  audio_i2s_bridge #(.BCLK_HALF(H), .SLOT_BITS(S), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(bclk), .i2s_lrck(lrck),
    .i2s_adcdat(adcdat), .i2s_dacdat(dacdat), .bus(bus)
  );

  audio_i2s_bridge #(.BCLK_HALF(H2), .SLOT_BITS(S2), .DW(16)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i2s_bclk(bclk2), .i2s_lrck(lrck2),
    .i2s_adcdat(adcdat2), .i2s_dacdat(dacdat2), .bus(bus2)
  );

  // Loopback wire with two clk of delay for the small instance.
  logic lb2_d1 = 1'b0, lb2_d2 = 1'b0;
  always @(posedge clk) begin
    lb2_d1 <= dacdat2;
    lb2_d2 <= lb2_d1;
  end
  assign adcdat2 = lb2_d2;

  // ---------------- vectors ----------------
  typedef struct {
    logic        lb;
    logic [15:0] txl, txr, adl, adr;
  } frame_t;
  frame_t tbl[NV];

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] m_txl, m_txr, m_rxl, m_rxr;
  logic        cur_lb;
  logic [15:0] cur_adl, cur_adr;
  logic        codec_bit, lb_d1, lb_d2;
  logic        p2_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Expected pin/strobe state after clk edge number cyc, derived from
  // the frame arithmetic: BCLK period 2H, falls at multiples of 2H,
  // fall n sets bit n-1 of the frame, rise after fall n at 2H*n+H,
  // ADC sample published 2 clk after the right-LSB rise.
  task automatic check_cycle();
    logic [4:0]  e;
    logic [15:0] w;
    int n, b, p, c2;
    e = '0;
    if (rst_n) begin
      n    = cyc / (2 * H);
      e[4] = ((cyc / H) % 2) == 1;
      if (n > 0) begin
        b    = (n - 1) % (2 * S);
        p    = b % S;
        w    = (b < S) ? m_txl : m_txr;
        e[3] = (b >= S);
        e[2] = (p >= 1 && p <= 16) ? w[16-p] : 1'b0;
        e[1] = (cyc % (2 * H) == 0) && (b == 0);
      end
      c2 = cyc - H - 2;
      e[0] = (c2 > 0) && (c2 % (2 * H) == 0) && (((c2 / (2 * H) - 1) % (2 * S)) == S + 16);
      if (e[0]) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_queue: strobe expected with no queued frame (cyc %0d)", cyc);
        end else begin
          {m_rxl, m_rxr} = exp_q.pop_front();
        end
      end
    end
    check("ctrl{bclk,lrck,dac,load,down}",
          64'({bclk, lrck, dacdat, bus.audio_tx_load, bus.audio_rx_down}), 64'(e));
    check("rx{left,right}", 64'({bus.rx_left, bus.rx_right}), 64'({m_rxl, m_rxr}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_tx(input logic [15:0] l, input logic [15:0] r);
    bus.tx_left  = l;
    bus.tx_right = r;
  endtask

  // One clk: model codec reacts to the BCLK fall, inputs move #1 after
  // the edge, outputs are compared on the falling clk edge.
  task automatic tick();
    logic [15:0] w;
    int n, b, p;
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      n = cyc / (2 * H);
      if (cyc % (2 * H) == 0) begin
        b = (n - 1) % (2 * S);
        p = b % S;
        if (b == 0) begin
          m_txl = bus.tx_left;
          m_txr = bus.tx_right;
        end
        w = (b < S) ? cur_adl : cur_adr;
        codec_bit = (p >= 1 && p <= 16) ? w[16-p] : 1'($urandom);
      end
    end
    #1;
    lb_d2  = lb_d1;
    lb_d1  = dacdat;
    adcdat = cur_lb ? lb_d2 : codec_bit;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    cyc   = 0;
    m_txl = '0; m_txr = '0; m_rxl = '0; m_rxr = '0;
    exp_q.delete();
    lb_d1 = 1'b0; lb_d2 = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // Apply frames tbl[start .. start+count-1] from a freshly released reset.
  task automatic run_frames(input int start, input int count);
    int idx, target;
    for (int k = 0; k < count; k++) begin
      idx    = start + k;
      target = 2 * H * (k * 2 * S + 1);
      while (cyc < target) tick();
      cur_lb  = tbl[idx].lb;
      cur_adl = tbl[idx].adl;
      cur_adr = tbl[idx].adr;
      exp_q.push_back(tbl[idx].lb ? {tbl[idx].txl, tbl[idx].txr}
                                  : {tbl[idx].adl, tbl[idx].adr});
      // Move tx while the left word of this frame is still going out.
      repeat (2 * H * 8) tick();
      if (idx + 1 < NV) set_tx(tbl[idx+1].txl, tbl[idx+1].txr);
    end
    target = 2 * H * ((count - 1) * 2 * S + S + 17) + H + 3;
    while (cyc < target) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{lb: 1'b0, txl: 16'h8001, txr: 16'h7FFE, adl: 16'h0000, adr: 16'h0000};
    tbl[1] = '{lb: 1'b1, txl: 16'h8001, txr: 16'h7FFE, adl: 16'h0000, adr: 16'h0000};
    tbl[2] = '{lb: 1'b0, txl: 16'h0001, txr: 16'h5AA5, adl: 16'hA5A5, adr: 16'h1234};
    tbl[3] = '{lb: 1'b1, txl: 16'hFFFF, txr: 16'h0000, adl: 16'h0000, adr: 16'h0000};
    tbl[4] = '{lb: 1'b0, txl: 16'($urandom), txr: 16'($urandom),
               adl: 16'($urandom), adr: 16'($urandom)};
    tbl[5] = '{lb: 1'b1, txl: 16'($urandom), txr: 16'($urandom), adl: 16'h0, adr: 16'h0};
    tbl[6] = '{lb: 1'b0, txl: 16'($urandom), txr: 16'($urandom),
               adl: 16'($urandom_range(0, 65535)), adr: 16'($urandom_range(0, 65535))};

    cur_lb = 1'b0; cur_adl = '0; cur_adr = '0;
    codec_bit = 1'b0; adcdat = 1'b0;
    set_tx(tbl[0].txl, tbl[0].txr);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    hold_reset(3);
    run_frames(0, 5);

    // Frame 5 starts; pull reset when the frame bit counter reaches 40.
    while (cyc < 2 * H * (5 * 2 * S + 41)) tick();
    set_tx(tbl[5].txl, tbl[5].txr);
    hold_reset(3);
    run_frames(5, 2);

    wait (p2_done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Small instance: loopback frame timing and sample integrity.
  initial begin
    int nstr, last;
    nstr = 0;
    last = 0;
    bus2.tx_left  = 16'h8001;
    bus2.tx_right = 16'h7FFE;
    rst2_n = 1'b1;
    #1 rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int c = 1; c <= 1200 && nstr < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus2.audio_rx_down) begin
        if (nstr == 0) check("p2_first_strobe", 64'(c), 64'(2 * H2 * (S2 + 17) + H2 + 2));
        else           check("p2_period", 64'(c - last), 64'(4 * H2 * S2));
        check("p2_rx", 64'({bus2.rx_left, bus2.rx_right}), 64'({16'h8001, 16'h7FFE}));
        nstr++;
        last = c;
      end
    end
    check("p2_strobe_count", 64'(nstr), 64'(3));
    p2_done = 1'b1;
  end
endmodule
